// File: rtl/mul_acc_ctrl.sv
// mul_acc_ctrl: operand sequencer and product accumulator around an external N x N multiplier
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand pair handshake (a, b, in_last)
//   mul_x, mul_y                registered operands to the multiplier
//   mul_p                       combinational product from the multiplier
//   out_valid/out_ready         group result handshake
//   acc_out, out_count          group sum of products and saturating product count
//   overflow                    sticky accumulator carry-out for the current group
module mul_acc_ctrl #(
  parameter int N = 32,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             in_last,
  output logic [N-1:0]     mul_x,
  output logic [N-1:0]     mul_y,
  input  logic [2*N-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t           state;
  logic             s1_valid, s1_last;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  assign in_ready  = state == RUN;
  assign sum       = {1'b0, acc} + (ACC_W+1)'(mul_p);
  assign acc_out   = acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      mul_x     <= '0;
      mul_y     <= '0;
      acc       <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        mul_x   <= a;
        mul_y   <= b;
        s1_last <= in_last;
        if (in_last) state <= FLUSH;
      end
      // The product of the pair captured last edge is on mul_p now.
      if (s1_valid) begin
        acc      <= sum[ACC_W-1:0];
        overflow <= overflow | sum[ACC_W];
        if (~&out_count) out_count <= out_count + CNT_W'(1);
        if (s1_last) begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        acc       <= '0;
        out_count <= '0;
        overflow  <= 1'b0;
        state     <= RUN;
      end
    end
  end
endmodule
